// File: rtl/lif_pkg.sv
// Shared types and default sizing for the LIF neuron front end.
package lif_pkg;

  localparam int LIF_SYNAPSES   = 32;
  localparam int LIF_VALUE_BITS = 8;
  localparam int LIF_STEPS      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/rate_channel.sv
// One synapse of the rate coder: stored intensity plus a phase accumulator.
// Spike is the carry of acc+intensity, combinational from registered state only.
module rate_channel #(
  parameter int VALUE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_i,
  input  logic [VALUE_BITS-1:0] wr_dat_i,
  input  logic                  clr_acc_i,
  input  logic                  adv_i,
  output logic                  spike_o
);

  logic [VALUE_BITS-1:0] intensity_q;
  logic [VALUE_BITS-1:0] acc_q;
  logic [VALUE_BITS:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, intensity_q};
  assign spike_o = acc_sum[VALUE_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intensity_q <= '0;
      acc_q       <= '0;
    end else begin
      if (wr_i) intensity_q <= wr_dat_i;
      if (clr_acc_i)  acc_q <= '0;
      else if (adv_i) acc_q <= acc_sum[VALUE_BITS-1:0];
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Loads one intensity per synapse, then streams STEPS rate-coded spike vectors.
// Load: 1 byte/cycle; first vector valid the cycle after the last byte; stalls hold all state.
module spike_rate_encoder
  import lif_pkg::*;
#(
  parameter int SYNAPSES   = LIF_SYNAPSES,
  parameter int VALUE_BITS = LIF_VALUE_BITS,
  parameter int STEPS      = LIF_STEPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load_valid,
  input  logic [VALUE_BITS-1:0] load_data,
  output logic                  load_ready,
  input  logic                  start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYNAPSES-1:0]   out_spikes,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W  = (SYNAPSES > 1) ? $clog2(SYNAPSES) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  enc_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STEP_W-1:0] step_q;
  logic              frame_done_q;

  logic load_hs, last_load, start_go, out_hs, last_step, clr_acc;
  logic [SYNAPSES-1:0] chan_spikes;

  assign load_ready = (state_q != RUN);
  assign out_valid  = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign out_spikes = out_valid ? chan_spikes : '0;

  // clear masks every handshake so nothing moves in an abort cycle
  assign load_hs   = load_valid & load_ready & ~clear;
  assign last_load = load_hs & (state_q == LOAD) & (idx_q == IDX_W'(SYNAPSES - 1));
  assign start_go  = ~clear & (state_q == IDLE) & ~load_valid & start;
  assign out_hs    = out_valid & out_ready & ~clear;
  assign last_step = out_hs & (step_q == STEP_W'(STEPS - 1));
  assign clr_acc   = clear | start_go | last_load;

  for (genvar g = 0; g < SYNAPSES; g++) begin : g_chan
    rate_channel #(
      .VALUE_BITS (VALUE_BITS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (load_hs & (idx_q == IDX_W'(g))),
      .wr_dat_i  (load_data),
      .clr_acc_i (clr_acc),
      .adv_i     (out_hs),
      .spike_o   (chan_spikes[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      step_q       <= '0;
      frame_done_q <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      step_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_step;
      case (state_q)
        IDLE: begin
          if (load_hs) begin
            idx_q   <= IDX_W'(1);
            state_q <= LOAD;
          end else if (start_go) begin
            step_q  <= '0;
            state_q <= RUN;
          end
        end
        LOAD: begin
          if (last_load) begin
            idx_q   <= '0;
            step_q  <= '0;
            state_q <= RUN;
          end else if (load_hs) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        RUN: begin
          if (last_step) begin
            step_q  <= '0;
            state_q <= IDLE;
          end else if (out_hs) begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
